// File: rtl/fft8_ctrl_agu.sv
// fft8_ctrl_agu: sequencer and address generator for an in-place 8-point
// radix-2 DIT FFT data RAM. Waits for the bit-reversed RAM load, runs 12
// butterflies (read, BF_LAT-cycle pipeline wait, write-back), then sweeps the
// RAM in natural order so downstream logic can unload the result bins.
// Optional build macro FFT8_AGU_PERF_EN adds a saturating 12-bit busy-cycle
// counter output cycle_cnt.
module fft8_ctrl_agu #(
  parameter int N      = 8,  // FFT points; only 8 is supported
  parameter int LOG2N  = 3,  // RAM address width
  parameter int BF_LAT = 4   // butterfly pipeline depth, 1..15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             initial_flag,
  input  logic             start,
  output logic             rd_en,
  output logic [LOG2N-1:0] rd_add1,
  output logic [LOG2N-1:0] rd_add2,
  output logic             wr_en,
  output logic [LOG2N-1:0] wr_add1,
  output logic [LOG2N-1:0] wr_add2,
  output logic [1:0]       tw_idx,
  output logic [1:0]       stage,
  output logic [LOG2N-1:0] read_addr,
  output logic             out_valid,
  output logic [LOG2N-1:0] out_idx,
  output logic             busy,
`ifdef FFT8_AGU_PERF_EN
  output logic [11:0]      cycle_cnt,
`endif
  output logic             done
);

  typedef logic [LOG2N-1:0] addr_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_INIT,
    READ,
    CALC,
    WRITE,
    UNLOAD,
    FLUSH,
    DONE
  } state_t;

  // Operand addresses and twiddle index for one butterfly.
  typedef struct packed {
    addr_t     a1;
    addr_t     a2;
    logic [1:0] tw;
  } bf_addr_t;

  localparam addr_t      LAST_ADDR = addr_t'(N - 1);
  localparam logic [3:0] CALC_LAST = 4'(BF_LAT - 1);

  // Butterfly b of stage s: span h = 1<<s, group base (b>>s)*2h, offset b&(h-1).
  function automatic bf_addr_t bf_addr(input logic [1:0] b, input logic [1:0] s);
    addr_t    h;
    addr_t    lo;
    bf_addr_t r;
    h    = addr_t'(1) << s;
    lo   = {1'b0, b} & (h - addr_t'(1));
    r.a1 = (({1'b0, b} >> s) << (s + 2'd1)) | lo;
    r.a2 = r.a1 + h;
    r.tw = 2'(lo << (2'd2 - s));
    return r;
  endfunction

  state_t     state_q;
  logic [1:0] b_q, s_q;
  logic [1:0] b_d, s_d;
  logic [3:0] calc_cnt_q;
  logic       rd_en_q, wr_en_q, busy_q, done_q;
  addr_t      rd_add1_q, rd_add2_q, wr_add1_q, wr_add2_q, read_addr_q;
  logic [1:0] tw_idx_q;
  logic       out_valid_q;
  addr_t      out_idx_q;
  logic       last_bf;
  bf_addr_t   first_bf, next_bf;

  // Butterfly counter advance: b wraps 3->0 and carries into the stage.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    b_d      = b_q + 2'd1;
    s_d      = s_q;
    if (b_q == 2'd3) s_d = s_q + 2'd1;
    last_bf  = (b_q == 2'd3) && (s_q == 2'd2);
    first_bf = bf_addr(b_q, s_q);
    next_bf  = bf_addr(b_d, s_d);
  end

  // Main sequencer: state, counters and all registered strobes/addresses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      b_q         <= '0;
      s_q         <= '0;
      calc_cnt_q  <= '0;
      rd_en_q     <= 1'b0;
      wr_en_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      rd_add1_q   <= '0;
      rd_add2_q   <= '0;
      wr_add1_q   <= '0;
      wr_add2_q   <= '0;
      tw_idx_q    <= '0;
      read_addr_q <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values, like real flops.
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= WAIT_INIT;
            busy_q  <= 1'b1;
            b_q     <= '0;
            s_q     <= '0;
          end
        end
        WAIT_INIT: begin
          if (initial_flag) begin
            state_q   <= READ;
            rd_en_q   <= 1'b1;
            rd_add1_q <= first_bf.a1;
            rd_add2_q <= first_bf.a2;
            tw_idx_q  <= first_bf.tw;
          end
        end
        READ: begin
          state_q    <= CALC;
          calc_cnt_q <= CALC_LAST;
        end
        CALC: begin
          if (calc_cnt_q == 4'd0) begin
            state_q   <= WRITE;
            wr_en_q   <= 1'b1;
            wr_add1_q <= rd_add1_q;
            wr_add2_q <= rd_add2_q;
          end else begin
            calc_cnt_q <= calc_cnt_q - 4'd1;
          end
        end
        WRITE: begin
          if (last_bf) begin
            state_q     <= UNLOAD;
            rd_en_q     <= 1'b1;
            read_addr_q <= '0;
            rd_add1_q   <= '0;
            rd_add2_q   <= '0;
            tw_idx_q    <= '0;
            b_q         <= '0;
            s_q         <= '0;
          end else begin
            state_q   <= READ;
            rd_en_q   <= 1'b1;
            b_q       <= b_d;
            s_q       <= s_d;
            rd_add1_q <= next_bf.a1;
            rd_add2_q <= next_bf.a2;
            tw_idx_q  <= next_bf.tw;
          end
        end
        UNLOAD: begin
          if (read_addr_q == LAST_ADDR) begin
            state_q <= FLUSH;
          end else begin
            rd_en_q     <= 1'b1;
            read_addr_q <= read_addr_q + addr_t'(1);
          end
        end
        FLUSH: begin
          state_q <= DONE;
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM read data appears one cycle after an unload read; tag it with its bin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
    end else begin
      out_valid_q <= (state_q == UNLOAD);
      out_idx_q   <= read_addr_q;
    end
  end

`ifdef FFT8_AGU_PERF_EN
  logic [11:0] cycle_cnt_q;

  // Busy-cycle counter: cleared on accepted start, saturating, frozen once busy drops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt_q <= '0;
    end else if (state_q == IDLE && start) begin
      cycle_cnt_q <= '0;
    end else if (busy_q && cycle_cnt_q != 12'hFFF) begin
      cycle_cnt_q <= cycle_cnt_q + 12'd1;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
`endif

  assign rd_en     = rd_en_q;
  assign rd_add1   = rd_add1_q;
  assign rd_add2   = rd_add2_q;
  assign wr_en     = wr_en_q;
  assign wr_add1   = wr_add1_q;
  assign wr_add2   = wr_add2_q;
  assign tw_idx    = tw_idx_q;
  assign stage     = s_q;
  assign read_addr = read_addr_q;
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fft8_ctrl_agu.sv
// tb_fft8_ctrl_agu: directed bench for fft8_ctrl_agu with a behavioural
// fixed-point RAM/butterfly model (1.0 = 1024). Define FFT8_AGU_PERF_EN to
// also check cycle_cnt.
module tb_fft8_ctrl_agu;

  logic       clk;
  logic       rst;
  logic       initial_flag;
  logic       start;
  logic       rd_en, wr_en, busy, done, out_valid;
  logic [2:0] rd_add1, rd_add2, wr_add1, wr_add2, read_addr, out_idx;
  logic [1:0] tw_idx, stage;
`ifdef FFT8_AGU_PERF_EN
  logic [11:0] cycle_cnt;
`endif

  fft8_ctrl_agu dut (
    .clk          (clk),
    .rst          (rst),
    .initial_flag (initial_flag),
    .start        (start),
    .rd_en        (rd_en),
    .rd_add1      (rd_add1),
    .rd_add2      (rd_add2),
    .wr_en        (wr_en),
    .wr_add1      (wr_add1),
    .wr_add2      (wr_add2),
    .tw_idx       (tw_idx),
    .stage        (stage),
    .read_addr    (read_addr),
    .out_valid    (out_valid),
    .out_idx      (out_idx),
    .busy         (busy),
`ifdef FFT8_AGU_PERF_EN
    .cycle_cnt    (cycle_cnt),
`endif
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Hand-derived butterfly schedule for an 8-point in-place DIT FFT.
  int exp_a1[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
  int exp_a2[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
  int exp_tw[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

  // W8^k scaled by 1024.
  int w_re[4] = '{1024, 724, 0, -724};
  int w_im[4] = '{0, -724, -1024, -724};

  // Expected bins: impulse at x[0] -> all ones; impulse at x[1] -> W8^k.
  int ones_re[8]  = '{1024, 1024, 1024, 1024, 1024, 1024, 1024, 1024};
  int zeros_im[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
  int shift_re[8] = '{1024, 724, 0, -724, -1024, -724, 0, 724};
  int shift_im[8] = '{0, -724, -1024, -724, 0, 724, 1024, 724};

  int ram_re[8], ram_im[8];
  int p1_re, p1_im, p2_re, p2_im;
  int cyc;
  int n_rd, n_wr, n_beat, n_done, busy_cnt, done_cyc;
  int rd_cyc[12], rd_a1[12], rd_a2[12], rd_tw[12], rd_st[12];
  int wr_cyc[12], wr_a1[12], wr_a2[12];
  int bt_idx[8], bt_re[8], bt_im[8], bt_cyc[8];

  function automatic int bitrev3(input int n);
    logic [2:0] v;
    v = n[2:0];
    return int'({v[0], v[1], v[2]});
  endfunction

  // Bit-reversed load of a unit impulse at x[pos].
  task automatic load_impulse(input int pos);
    for (int i = 0; i < 8; i++) begin
      ram_re[i] = 0;
      ram_im[i] = 0;
    end
    ram_re[bitrev3(pos)] = 1024;
  endtask

  task automatic clear_logs();
    n_rd = 0; n_wr = 0; n_beat = 0; n_done = 0; busy_cnt = 0; done_cyc = -1;
  endtask

  // One clock: wait for the falling edge, then act as RAM + butterfly + logger.
  task automatic tick();
    int br, bi, pr, pi, t;
    @(negedge clk);
    cyc++;
    if (busy) busy_cnt++;
    if (rd_en) begin
      if (n_rd < 12) begin
        rd_cyc[n_rd] = cyc; rd_a1[n_rd] = int'(rd_add1); rd_a2[n_rd] = int'(rd_add2);
        rd_tw[n_rd] = int'(tw_idx); rd_st[n_rd] = int'(stage);
        t  = int'(tw_idx);
        br = ram_re[rd_add2]; bi = ram_im[rd_add2];
        pr = (br * w_re[t] - bi * w_im[t]) >>> 10;
        pi = (br * w_im[t] + bi * w_re[t]) >>> 10;
        p1_re = ram_re[rd_add1] + pr; p1_im = ram_im[rd_add1] + pi;
        p2_re = ram_re[rd_add1] - pr; p2_im = ram_im[rd_add1] - pi;
      end
      n_rd++;
    end
    if (wr_en) begin
      ram_re[wr_add1] = p1_re; ram_im[wr_add1] = p1_im;
      ram_re[wr_add2] = p2_re; ram_im[wr_add2] = p2_im;
      if (n_wr < 12) begin
        wr_cyc[n_wr] = cyc; wr_a1[n_wr] = int'(wr_add1); wr_a2[n_wr] = int'(wr_add2);
      end
      n_wr++;
    end
    if (out_valid) begin
      if (n_beat < 8) begin
        bt_idx[n_beat] = int'(out_idx); bt_cyc[n_beat] = cyc;
        bt_re[n_beat] = ram_re[out_idx]; bt_im[n_beat] = ram_im[out_idx];
      end
      n_beat++;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
  endtask

  task automatic check_idle_outs(input string tag);
    check(tag, int'({rd_en, wr_en, busy, done, out_valid, rd_add1, rd_add2,
                     wr_add1, wr_add2, tw_idx, stage, read_addr, out_idx}), 0);
`ifdef FFT8_AGU_PERF_EN
    check({tag, "_cnt"}, int'(cycle_cnt), 0);
`endif
  endtask

  task automatic start_run();
    clear_logs();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Run until done, optionally pulsing start once at tick restart_at.
  task automatic wait_done(input string tag, input int restart_at);
    for (int i = 0; i < 400 && n_done == 0; i++) begin
      start = (i == restart_at);
      tick();
    end
    start = 1'b0;
    check({tag, "_done_seen"}, n_done, 1);
  endtask

  task automatic check_bins(input string tag, input int er[8], input int ei[8]);
    check({tag, "_beats"}, n_beat, 8);
    check({tag, "_writes"}, n_wr, 12);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_idx%0d", tag, i), bt_idx[i], i);
      check($sformatf("%s_bin%0d_re", tag, i), bt_re[i], er[i]);
      check($sformatf("%s_bin%0d_im", tag, i), bt_im[i], ei[i]);
      check($sformatf("%s_beat%0d_cyc", tag, i), bt_cyc[i] - bt_cyc[0], i);
    end
    check({tag, "_done_lat"}, done_cyc - bt_cyc[7], 1);
    check({tag, "_busy_at_done"}, int'(busy), 0);
  endtask

  initial begin
    cyc = 0;
    clear_logs();
    load_impulse(0);

    // T1: reset held with start high keeps everything at zero.
    rst = 1'b0; start = 1'b1; initial_flag = 1'b0;
    repeat (3) tick();
    check_idle_outs("t1_reset_a");
    repeat (3) tick();
    check_idle_outs("t1_reset_b");
    start = 1'b0;
    rst = 1'b1;
    tick();
    check_idle_outs("t1_after_release");

    // T2: start without init flag must not read.
    start_run();
    repeat (10) tick();
    check("t2_no_rd", n_rd, 0);
    check("t2_busy", int'(busy), 1);
    initial_flag = 1'b1;
    tick();
    check("t2_rd_en", int'(rd_en), 1);
    check("t2_add1", int'(rd_add1), 0);
    check("t2_add2", int'(rd_add2), 1);
    check("t2_tw", int'(tw_idx), 0);
    wait_done("t2", -1);

    // T3: butterfly schedule and read-to-write spacing.
    check("t3_rd_total", n_rd, 20);
    for (int i = 0; i < 12; i++) begin
      check($sformatf("t3_rd%0d_a1", i), rd_a1[i], exp_a1[i]);
      check($sformatf("t3_rd%0d_a2", i), rd_a2[i], exp_a2[i]);
      check($sformatf("t3_rd%0d_tw", i), rd_tw[i], exp_tw[i]);
      check($sformatf("t3_rd%0d_stage", i), rd_st[i], i / 4);
      check($sformatf("t3_wr%0d_a1", i), wr_a1[i], exp_a1[i]);
      check($sformatf("t3_wr%0d_a2", i), wr_a2[i], exp_a2[i]);
      check($sformatf("t3_wr%0d_lat", i), wr_cyc[i] - rd_cyc[i], 5);
    end

    // T4: impulse at x[0] gives a flat spectrum.
    check_bins("t4", ones_re, zeros_im);
    tick();
    check("t4_idle_busy", int'(busy), 0);

    // T5: impulse at x[1] gives W8^k; a start mid-run is ignored.
    load_impulse(1);
    start_run();
    wait_done("t5", 20);
    check_bins("t5", shift_re, shift_im);
    check("t5_busy_cycles", busy_cnt, 82);
    tick();

    // T6: reset during stage-1 CALC, then a clean rerun.
    load_impulse(0);
    start_run();
    for (int i = 0; i < 200 && n_rd < 5; i++) tick();
    check("t6_reached_stage1", n_rd, 5);
    repeat (2) tick();
    rst = 1'b0;
    repeat (10) tick();
    check("t6_no_write_after_rst", n_wr, 4);
    check("t6_no_read_after_rst", n_rd, 5);
    check_idle_outs("t6_reset_outs");
    rst = 1'b1;
    tick();
    load_impulse(0);
    start_run();
    wait_done("t6", -1);
    check_bins("t6", ones_re, zeros_im);
    check("t6_busy_cycles", busy_cnt, 82);
`ifdef FFT8_AGU_PERF_EN
    check("t6_cycle_cnt", int'(cycle_cnt), 82);
    repeat (3) tick();
    check("t6_cycle_cnt_frozen", int'(cycle_cnt), 82);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
